// File: rtl/pcs_pkg.sv
// pcs_pkg: shared widths, reset value and PC type for the PC sequencer.
// Optional feature in pc_sequencer: define PCS_RA_OUT_EN to expose the RA register.
package pcs_pkg;
   localparam int PC_WIDTH = 16;
   typedef logic [PC_WIDTH-1:0] pc_t;
   localparam pc_t RESET_PC = 16'h0000;
endpackage

// File: rtl/adder_16_bit.sv
// adder_16_bit: generic A+B adder, carry-out discarded.
module adder_16_bit import pcs_pkg::*; #(
   parameter int WIDTH = PC_WIDTH
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] R
);
   assign R = A + B;
endmodule

// File: rtl/mux_1_bit.sv
// mux_1_bit: 2:1 mux with a 1-bit select, R = S ? B : A.
module mux_1_bit import pcs_pkg::*; #(
   parameter int WIDTH = PC_WIDTH
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             S,
   output logic [WIDTH-1:0] R
);
   assign R = S ? B : A;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC and return-address registers with PC+1 / immediate / RA next-PC selection.
// Define PCS_RA_OUT_EN to add the RA debug/forwarding output port.
module pc_sequencer import pcs_pkg::*; #(
   parameter int               WIDTH    = PC_WIDTH,
   parameter logic [WIDTH-1:0] RESET_PC = pcs_pkg::RESET_PC
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             writePC,
   input  logic             writeRA,
   input  logic             PCsrc,
   input  logic             ImRPC,
   input  logic             conditionalBop,
   input  logic [WIDTH-1:0] ImR,
`ifdef PCS_RA_OUT_EN
   output logic [WIDTH-1:0] RA,
`endif
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] PC_1
);
   logic [WIDTH-1:0] pc_q, pc_d, ra_q, ra_d, imm_pc, next_pc;

   adder_16_bit #(.WIDTH(WIDTH)) u_add (.A(pc_q), .B(WIDTH'(1)), .R(PC_1));

   // Immediate target wins over the increment for jumps and taken branches.
   mux_1_bit #(.WIDTH(WIDTH)) u_mux_imm (.A(PC_1), .B(ImR), .S(ImRPC | conditionalBop), .R(imm_pc));

   // Return to RA overrides everything else.
   mux_1_bit #(.WIDTH(WIDTH)) u_mux_ret (.A(imm_pc), .B(ra_q), .S(PCsrc), .R(next_pc));

   // Registers hold unless their write enable is asserted.
   always_comb begin
      pc_d = writePC ? next_pc : pc_q;
      ra_d = writeRA ? PC_1 : ra_q;
   end

   // Both registers sample pre-edge values, so a call/return swap is well defined.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
         ra_q <= '0;
      end else begin
         pc_q <= pc_d;
         ra_q <= ra_d;
      end
   end

   assign PC = pc_q;
`ifdef PCS_RA_OUT_EN
   assign RA = ra_q;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a behavioural model.
// Build with PCS_RA_OUT_EN defined to also check the RA output port.
module tb_pc_sequencer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        writePC, writeRA, PCsrc, ImRPC, conditionalBop;
   logic [15:0] ImR, PC, PC_1;
`ifdef PCS_RA_OUT_EN
   logic [15:0] RA;
`endif
   logic [15:0] ta, tb, tr_add, tr_mux;
   logic        ts;
   int          checks = 0;
   int          errors = 0;
   int          m_pc, m_ra;

   pc_sequencer dut (
      .clk(clk), .rst_n(rst_n), .writePC(writePC), .writeRA(writeRA), .PCsrc(PCsrc),
      .ImRPC(ImRPC), .conditionalBop(conditionalBop), .ImR(ImR),
`ifdef PCS_RA_OUT_EN
      .RA(RA),
`endif
      .PC(PC), .PC_1(PC_1)
   );

   adder_16_bit u_add (.A(ta), .B(tb), .R(tr_add));
   mux_1_bit    u_mux (.A(ta), .B(tb), .S(ts), .R(tr_mux));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_state(input string tag);
      chk({tag, ".pc"}, PC, 16'(m_pc));
      chk({tag, ".pc1"}, PC_1, 16'((m_pc + 1) % 65536));
`ifdef PCS_RA_OUT_EN
      chk({tag, ".ra"}, RA, 16'(m_ra));
`endif
   endtask

   // Present inputs, take one edge, advance the model, check 1 time unit later.
   task automatic step(input string tag, input logic wpc, input logic wra, input logic src,
                       input logic imm, input logic cb, input logic [15:0] tgt);
      int nxt;
      writePC = wpc; writeRA = wra; PCsrc = src; ImRPC = imm; conditionalBop = cb; ImR = tgt;
      @(posedge clk);
      if (src) nxt = m_ra;
      else if (imm || cb) nxt = int'(tgt);
      else nxt = (m_pc + 1) % 65536;
      if (wra) m_ra = (m_pc + 1) % 65536;
      if (wpc) m_pc = nxt;
      #1;
      chk_state(tag);
   endtask

   // Asynchronous reset pulse between edges, with writes requested throughout.
   task automatic async_rst(input string tag);
      #2;
      writePC = 1'b1; writeRA = 1'b1; ImRPC = 1'b1; ImR = 16'h1234;
      rst_n = 1'b0;
      m_pc = 0; m_ra = 0;
      #1;
      chk_state(tag);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      writePC = 1'b0; writeRA = 1'b0; PCsrc = 1'b0; ImRPC = 1'b0; conditionalBop = 1'b0; ImR = '0;
      ta = '0; tb = '0; ts = 1'b0;
      m_pc = 0; m_ra = 0;
      #2;
      chk("rst.pc", PC, 16'h0000);
      chk("rst.pc1", PC_1, 16'h0001);
      #1 rst_n = 1'b1;
      step("inc1", 1, 0, 0, 0, 0, 16'hdead);
      chk("inc1.c", PC, 16'h0001);
      step("inc2", 1, 0, 0, 0, 0, 16'hdead);
      step("inc3", 1, 0, 0, 0, 0, 16'hdead);
      chk("inc3.c", PC, 16'h0003);
      step("jump", 1, 1, 0, 1, 0, 16'h0040);
      chk("jump.c", PC, 16'h0040);
      chk("jump.c1", PC_1, 16'h0041);
      step("br", 1, 0, 0, 0, 1, 16'h0100);
      chk("br.c", PC, 16'h0100);
      step("br_hold", 0, 0, 0, 0, 1, 16'h0300);
      chk("br_hold.c", PC, 16'h0100);
      step("ret", 1, 0, 1, 1, 0, 16'h0200);
      chk("ret.c", PC, 16'h0004);
      step("wrap_ld", 1, 0, 0, 1, 0, 16'hffff);
      chk("wrap_ld.c1", PC_1, 16'h0000);
      step("wrap", 1, 0, 0, 0, 0, 16'h0000);
      chk("wrap.c", PC, 16'h0000);
      step("pre_rst", 1, 0, 0, 0, 1, 16'h0100);
      async_rst("arst");
      chk("arst.c", PC, 16'h0000);
      step("ra_cleared", 1, 0, 1, 0, 0, 16'h0000);
      chk("ra_cleared.c", PC, 16'h0000);
      step("swap_a", 1, 1, 0, 1, 0, 16'h0777);
      step("swap_b", 1, 1, 1, 0, 0, 16'h0000);
      chk("swap_b.c", PC, 16'h0001);
      step("swap_c", 1, 0, 1, 0, 0, 16'h0000);
      chk("swap_c.c", PC, 16'h0778);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) async_rst("rnd_rst");
         else step("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 4) == 0),
                   1'($urandom_range(0, 4) == 0),
                   ($urandom_range(0, 7) == 0) ? 16'hffff : 16'($urandom));
      end
      for (int i = 0; i < 24; i++) begin
         ta = (i == 0) ? 16'hffff : 16'($urandom);
         tb = (i == 0) ? 16'h0001 : 16'($urandom);
         ts = 1'($urandom_range(0, 1));
         #1;
         chk("leaf.add", tr_add, 16'((int'(ta) + int'(tb)) % 65536));
         chk("leaf.mux", tr_mux, ts ? tb : ta);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
